// File: rtl/pio_arb_if.sv
// pio_arb_if: one PIO bus. The request side (valid/write/addr/wdata) is
// driven by the master and the response side (ack/err/rdata) by the slave.
interface pio_arb_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              valid;
  logic              write;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic              err;
  logic [DATA_W-1:0] rdata;

  modport master (output valid, write, addr, wdata, input ack, err, rdata);
  modport slave  (input valid, write, addr, wdata, output ack, err, rdata);
endinterface

// File: rtl/pio_arb.sv
// pio_arb: round-robin arbiter sharing one PIO slave bus between two masters.
// Each grant covers exactly one transaction. The slave request and the
// master responses are registered, and each response is a one-cycle pulse
// delivered only to the master that owns the bus.
// Optional feature macro: PIO_ARB_TIMEOUT_EN adds a slave-response watchdog
// (TIMEOUT cycles); the TIMEOUT parameter exists only when it is defined.
module pio_arb #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
`ifdef PIO_ARB_TIMEOUT_EN
  , parameter int TIMEOUT = 255
`endif
) (
  input logic      clk,
  input logic      reset,
  pio_arb_if.slave m0,
  pio_arb_if.slave m1,
  pio_arb_if.master s
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t            state;
  logic              owner;
  logic              ptr;
  logic              grant0;
  logic              grant1;
  logic              rsp_done;
  logic              rsp_err;
  logic [DATA_W-1:0] rsp_data;

`ifdef PIO_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  logic [CNT_W-1:0] cnt;
`endif

  // Arbitration choice: a lone requester always wins, a tie goes to the pointer
  always_comb begin
    grant0 = m0.valid && (!m1.valid || !ptr);
    grant1 = m1.valid && !grant0;
  end

  // Completion of the slave phase: a real s_ack, or the watchdog giving up
  always_comb begin
    rsp_done = s.ack;
    rsp_err  = s.err;
    rsp_data = s.rdata;
`ifdef PIO_ARB_TIMEOUT_EN
    if (!s.ack && (cnt == CNT_LAST)) begin
      rsp_done = 1'b1;
      rsp_err  = 1'b1;
      rsp_data = {DATA_W{1'b0}};
    end
`endif
  end

  // Arbitration FSM with registered slave request and master responses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      owner    <= 1'b0;
      ptr      <= 1'b0;
      s.valid  <= 1'b0;
      s.write  <= 1'b0;
      s.addr   <= {ADDR_W{1'b0}};
      s.wdata  <= {DATA_W{1'b0}};
      m0.ack   <= 1'b0;
      m0.err   <= 1'b0;
      m0.rdata <= {DATA_W{1'b0}};
      m1.ack   <= 1'b0;
      m1.err   <= 1'b0;
      m1.rdata <= {DATA_W{1'b0}};
`ifdef PIO_ARB_TIMEOUT_EN
      cnt      <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            owner   <= grant1;
            s.valid <= 1'b1;
            s.write <= grant1 ? m1.write : m0.write;
            s.addr  <= grant1 ? m1.addr  : m0.addr;
            s.wdata <= grant1 ? m1.wdata : m0.wdata;
`ifdef PIO_ARB_TIMEOUT_EN
            cnt     <= '0;
`endif
            state   <= REQ;
          end
        end
        REQ: begin
          if (rsp_done) begin
            if (!owner) begin
              m0.ack   <= 1'b1;
              m0.err   <= rsp_err;
              m0.rdata <= rsp_data;
            end else begin
              m1.ack   <= 1'b1;
              m1.err   <= rsp_err;
              m1.rdata <= rsp_data;
            end
            s.valid <= 1'b0;
            state   <= RESP;
          end
`ifdef PIO_ARB_TIMEOUT_EN
          else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        RESP: begin
          m0.ack <= 1'b0;
          m0.err <= 1'b0;
          m1.ack <= 1'b0;
          m1.err <= 1'b0;
          ptr    <= ~owner;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pio_arb.sv
// tb_pio_arb: self-checking bench for pio_arb. Directed reset / read / reset
// mid-transaction sequences, a table of single transactions covering the
// round-robin rules, and a randomized run compared against a transaction
// level model. The watchdog sequence is built only with PIO_ARB_TIMEOUT_EN.
module tb_pio_arb;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
`ifdef PIO_ARB_TIMEOUT_EN
  localparam int TIMEOUT = 8;
`endif

  typedef struct {
    bit          v0;
    bit          v1;
    bit          w0;
    bit          w1;
    logic [31:0] a0;
    logic [31:0] a1;
    logic [31:0] d0;
    logic [31:0] d1;
    int          delay;
    bit          serr;
    logic [31:0] rdata;
    bit          expOwner;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  // reference model state and its predicted outputs
  int          mOwner;
  bit          mResp;
  bit          mPtr;
  int          mReqCycles;
  logic        eSValid;
  logic        eSWrite;
  logic [31:0] eSAddr;
  logic [31:0] eSWdata;
  logic [1:0]  eAck;
  logic [1:0]  eErr;
  logic [31:0] eRdata [2];

  // random stimulus bookkeeping
  bit          pend [2];
  bit          slvSeen;
  int          slvDelay;

  vec_t vecs [9];

  always #5 clk = ~clk;

  pio_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m0 ();
  pio_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m1 ();
  pio_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) s ();

  pio_arb #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
`ifdef PIO_ARB_TIMEOUT_EN
    , .TIMEOUT(TIMEOUT)
`endif
  ) dut (
    .clk(clk),
    .reset(reset),
    .m0(m0),
    .m1(m1),
    .s(s)
  );

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic driveMaster(input int idx, input bit v, input bit w, input logic [31:0] a, input logic [31:0] d);
    if (idx == 0) begin
      m0.valid = v; m0.write = w; m0.addr = a; m0.wdata = d;
    end else begin
      m1.valid = v; m1.write = w; m1.addr = a; m1.wdata = d;
    end
  endtask

  task automatic doReset();
    reset = 1'b0;
    driveMaster(0, 0, 0, 32'h0, 32'h0);
    driveMaster(1, 0, 0, 32'h0, 32'h0);
    s.ack = 1'b0; s.err = 1'b0; s.rdata = 32'h0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  // one table entry: grant, hold through the slave delay, ack routing, release
  task automatic applyStimulus(input vec_t v, input int n);
    string       tag;
    bit          o;
    bit          ew;
    logic [31:0] ea;
    logic [31:0] ed;
    tag = $sformatf("vec%0d", n);
    o   = v.expOwner;
    ew  = o ? v.w1 : v.w0;
    ea  = o ? v.a1 : v.a0;
    ed  = o ? v.d1 : v.d0;
    driveMaster(0, v.v0, v.w0, v.a0, v.d0);
    driveMaster(1, v.v1, v.w1, v.a1, v.d1);
    tick();
    checkOutput({tag, "_grant"}, {s.valid, s.write, s.addr, s.wdata}, {1'b1, ew, ea, ed});
    for (int i = 0; i < v.delay; i++) begin
      tick();
      checkOutput({tag, "_hold"}, {s.valid, s.write, s.addr, s.wdata, m0.ack, m1.ack}, {1'b1, ew, ea, ed, 2'b00});
    end
    s.ack = 1'b1; s.err = v.serr; s.rdata = v.rdata;
    tick();
    s.ack = 1'b0; s.err = 1'b0; s.rdata = $urandom;
    driveMaster(0, 0, 0, 32'h0, 32'h0);
    driveMaster(1, 0, 0, 32'h0, 32'h0);
    checkOutput({tag, "_ack"}, {m0.ack, m0.err, m1.ack, m1.err, s.valid},
                {~o, ~o & v.serr, o, o & v.serr, 1'b0});
    checkOutput({tag, "_rdata"}, o ? m1.rdata : m0.rdata, v.rdata);
    tick();
    checkOutput({tag, "_done"}, {m0.ack, m0.err, m1.ack, m1.err, s.valid}, 5'b0);
  endtask

  task automatic modelReset();
    mOwner = -1; mResp = 0; mPtr = 0; mReqCycles = 0;
    eSValid = 0; eSWrite = 0; eSAddr = 0; eSWdata = 0;
    eAck = 0; eErr = 0; eRdata[0] = 0; eRdata[1] = 0;
  endtask

  task automatic modelDeliver(input bit err, input logic [31:0] data);
    eAck[mOwner]   = 1'b1;
    eErr[mOwner]   = err;
    eRdata[mOwner] = data;
    eSValid        = 1'b0;
    mResp          = 1;
  endtask

  // transaction-level prediction of the outputs after the next clock edge
  task automatic modelStep();
    int win;
    eAck = 2'b00;
    eErr = 2'b00;
    if (mResp) begin
      mResp  = 0;
      mPtr   = (mOwner == 0);
      mOwner = -1;
    end else if (mOwner < 0) begin
      if (m0.valid || m1.valid) begin
        if (m0.valid && m1.valid) win = int'(mPtr);
        else win = m1.valid ? 1 : 0;
        mOwner     = win;
        mReqCycles = 0;
        eSValid    = 1'b1;
        eSWrite    = win ? m1.write : m0.write;
        eSAddr     = win ? m1.addr  : m0.addr;
        eSWdata    = win ? m1.wdata : m0.wdata;
      end
    end else if (s.ack) begin
      modelDeliver(s.err, s.rdata);
    end else begin
      mReqCycles++;
`ifdef PIO_ARB_TIMEOUT_EN
      if (mReqCycles == TIMEOUT) modelDeliver(1'b1, 32'h0);
`endif
    end
  endtask

  initial begin
    reset = 1'b1;
    driveMaster(0, 0, 0, 32'h0, 32'h0);
    driveMaster(1, 0, 0, 32'h0, 32'h0);
    s.ack = 1'b0; s.err = 1'b0; s.rdata = 32'h0;

    vecs[0] = '{1, 1, 0, 0, 32'h100, 32'h200, 32'h0, 32'h0, 0, 0, 32'h1111_0000, 0};
    vecs[1] = '{1, 1, 0, 1, 32'h104, 32'h204, 32'h0, 32'hBEEF, 1, 0, 32'h2222_0001, 1};
    vecs[2] = '{1, 1, 1, 0, 32'h108, 32'h208, 32'hA5A5, 32'h0, 0, 0, 32'h3333_0002, 0};
    vecs[3] = '{1, 1, 0, 1, 32'h10C, 32'h20, 32'h0, 32'h1234, 2, 1, 32'h4444_0003, 1};
    vecs[4] = '{1, 0, 0, 0, 32'h110, 32'h0, 32'h0, 32'h0, 0, 0, 32'h5555_0004, 0};
    vecs[5] = '{1, 0, 1, 0, 32'h114, 32'h0, 32'h77, 32'h0, 3, 0, 32'h6666_0005, 0};
    vecs[6] = '{0, 1, 0, 0, 32'h0, 32'h218, 32'h0, 32'h0, 0, 1, 32'h7777_0006, 1};
    vecs[7] = '{0, 1, 0, 1, 32'h0, 32'h21C, 32'h0, 32'h99, 1, 0, 32'h8888_0007, 1};
    vecs[8] = '{1, 1, 0, 0, 32'h120, 32'h220, 32'h0, 32'h0, 0, 0, 32'h9999_0008, 0};

    // reset held with a pending request and noise on the slave inputs
    #2;
    reset = 1'b0;
    driveMaster(0, 1, 0, 32'h10, 32'h0BAD_0BAD);
    s.ack = 1'b1; s.err = 1'b1; s.rdata = $urandom;
    tick();
    tick();
    checkOutput("rst_sreq", {s.valid, s.write, s.addr, s.wdata}, 66'h0);
    checkOutput("rst_m0", {m0.ack, m0.err, m0.rdata}, 34'h0);
    checkOutput("rst_m1", {m1.ack, m1.err, m1.rdata}, 34'h0);
    s.ack = 1'b0; s.err = 1'b0;
    reset = 1'b1;
    checkOutput("rst_release_no_grant_yet", {31'h0, s.valid}, 32'h0);
    tick();
    checkOutput("rst_first_grant", {s.valid, s.write, s.addr}, {1'b1, 1'b0, 32'h10});

    // single read continues from the request granted above
    tick();
    checkOutput("read_hold", {s.valid, s.addr, m0.ack}, {1'b1, 32'h10, 1'b0});
    tick();
    s.ack = 1'b1; s.err = 1'b0; s.rdata = 32'hCAFE_F00D;
    tick();
    s.ack = 1'b0; s.rdata = 32'h0;
    driveMaster(0, 0, 0, 32'h0, 32'h0);
    checkOutput("read_ack", {m0.ack, m0.err, m0.rdata, m1.ack, s.valid}, {1'b1, 1'b0, 32'hCAFE_F00D, 1'b0, 1'b0});
    tick();
    checkOutput("read_ack_pulse", {m0.ack, m0.err, m0.rdata, m1.ack}, {1'b0, 1'b0, 32'hCAFE_F00D, 1'b0});

    // table of single transactions starting with the pointer at master 0
    doReset();
    for (int i = 0; i < 9; i++) applyStimulus(vecs[i], i);

    // reset asserted while the slave request is outstanding
    doReset();
    driveMaster(1, 1, 0, 32'h300, 32'h0);
    tick();
    checkOutput("rstmid_grant", {s.valid, s.addr}, {1'b1, 32'h300});
    #2;
    reset = 1'b0;
    #1;
    checkOutput("rstmid_async", {s.valid, m0.ack, m1.ack}, 3'b000);
    @(posedge clk);
    #1;
    reset = 1'b1;
    checkOutput("rstmid_held", {s.valid, m1.ack, m1.err}, 3'b000);
    tick();
    checkOutput("rstmid_reissue", {s.valid, s.addr}, {1'b1, 32'h300});
    s.ack = 1'b1; s.err = 1'b0; s.rdata = 32'h5A5A_0000;
    tick();
    s.ack = 1'b0;
    driveMaster(1, 0, 0, 32'h0, 32'h0);
    checkOutput("rstmid_ack", {m0.ack, m1.ack, m1.err, m1.rdata}, {1'b0, 1'b1, 1'b0, 32'h5A5A_0000});
    tick();

`ifdef PIO_ARB_TIMEOUT_EN
    // slave never answers: the watchdog completes the transaction with an error
    doReset();
    driveMaster(0, 1, 0, 32'h10, 32'h0);
    s.rdata = 32'hFFFF_FFFF;
    tick();
    checkOutput("to_grant", {s.valid, s.addr}, {1'b1, 32'h10});
    for (int i = 1; i < TIMEOUT; i++) begin
      tick();
      checkOutput("to_waiting", {s.valid, m0.ack}, 2'b10);
    end
    tick();
    driveMaster(0, 0, 0, 32'h0, 32'h0);
    checkOutput("to_fire", {m0.ack, m0.err, m0.rdata, s.valid, m1.ack}, {1'b1, 1'b1, 32'h0, 1'b0, 1'b0});
    s.ack = 1'b1; s.err = 1'b0;
    tick();
    checkOutput("to_late_ack_resp", {m0.ack, m0.err, m1.ack, s.valid}, 4'b0000);
    tick();
    s.ack = 1'b0;
    checkOutput("to_late_ack_idle", {m0.ack, m1.ack, s.valid, m0.rdata}, {3'b000, 32'h0});
`endif

    // randomized traffic against the reference model
    doReset();
    modelReset();
    pend[0] = 0; pend[1] = 0;
    slvSeen = 0; slvDelay = 0;
    for (int c = 0; c < 3000; c++) begin
      checkOutput("rand_sreq", {s.valid, s.write, s.addr, s.wdata}, {eSValid, eSWrite, eSAddr, eSWdata});
      checkOutput("rand_m0", {m0.ack, m0.err, m0.rdata}, {eAck[0], eErr[0], eRdata[0]});
      checkOutput("rand_m1", {m1.ack, m1.err, m1.rdata}, {eAck[1], eErr[1], eRdata[1]});
      if (s.valid) begin
        if (!slvSeen) begin
          slvSeen  = 1;
          slvDelay = $urandom_range(0, 3);
        end
        if (slvDelay == 0) begin
          s.ack = 1'b1; s.err = $urandom_range(0, 1); s.rdata = $urandom;
        end else begin
          slvDelay--;
          s.ack = 1'b0; s.err = $urandom_range(0, 1); s.rdata = $urandom;
        end
      end else begin
        slvSeen = 0;
        s.ack   = ($urandom_range(0, 7) == 0);
        s.err   = $urandom_range(0, 1);
        s.rdata = $urandom;
      end
      if (m0.ack) pend[0] = 0;
      if (m1.ack) pend[1] = 0;
      for (int k = 0; k < 2; k++) begin
        if (!pend[k] && $urandom_range(0, 2) != 0) begin
          pend[k] = 1;
          driveMaster(k, 1, $urandom_range(0, 1), $urandom, $urandom);
        end else if (!pend[k]) begin
          driveMaster(k, 0, 0, 32'h0, 32'h0);
        end
      end
      modelStep();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pio_arb.md
Name: pio_arb

Overview:
- Two-master arbiter that shares one PIO slave bus between the host bridge (master 0) and a second requester such as a DMA or debug master (master 1).
- Requests are granted round-robin; each grant lasts for exactly one transaction.
- Slave-side outputs are registered, and each response is returned as a single-cycle pulse to the owning master only.
- Sits between the PIO masters and the PIO slave blocks in the top level.

Parameters:
ADDR_W, 32, PIO address width
DATA_W, 32, PIO data width
TIMEOUT, 255, slave-response watchdog limit in cycles (used only with the optional feature)

Ports:
clk  in  1  sole clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = in reset)
m0_valid  in  1  master 0 request; held until m0_ack
m0_write  in  1  master 0: 1 = write, 0 = read
m0_addr  in  ADDR_W  master 0 address
m0_wdata  in  DATA_W  master 0 write data
m0_ack  out  1  master 0 completion pulse
m0_err  out  1  master 0 error, valid with m0_ack
m0_rdata  out  DATA_W  master 0 read data, valid with m0_ack
m1_valid, m1_write, m1_addr, m1_wdata, m1_ack, m1_err, m1_rdata: same as master 0, for master 1
s_valid  out  1  slave request
s_write  out  1  slave write/read
s_addr  out  ADDR_W  slave address
s_wdata  out  DATA_W  slave write data
s_ack  in  1  slave completion, one-cycle pulse
s_err  in  1  slave error, valid with s_ack
s_rdata  in  DATA_W  slave read data, valid with s_ack

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, priority pointer=0.
  - All outputs 0: s_valid/s_write/s_addr/s_wdata, mX_ack/mX_err/mX_rdata.
  - A transaction in flight is dropped. No ack is issued; the master's valid is simply seen again after reset releases.
- Master rule: mX_valid/write/addr/wdata stay stable from assertion until the cycle mX_ack=1. The master deasserts or changes them on the following edge.
- FSM states: IDLE, REQ, RESP. The owner register records the granted master.
- IDLE:
  - No mX_valid: stay in IDLE.
  - Only one valid: grant that master.
  - Both valid: grant the master named by the pointer.
  - On grant, latch owner and its write/addr/wdata into the s_* registers, set s_valid=1, go to REQ.
  - Latency: s_valid rises the cycle after mX_valid is sampled.
- REQ:
  - Hold s_* stable until s_ack=1.
  - On s_ack: register s_rdata/s_err into the owner's mX_rdata/mX_err, set owner mX_ack=1, clear s_valid, go to RESP.
  - s_rdata is captured for writes too.
- RESP:
  - mX_ack/mX_err/mX_rdata are held exactly one cycle.
  - Then clear mX_ack and mX_err, and set pointer = other master (the one not just served).
  - Go to IDLE. mX_rdata holds its last value.
- The non-owner's ack/err stay 0 throughout.
- s_ack while in IDLE or RESP is ignored.
- Minimum transaction: valid sampled (N) -> s_valid (N+1) -> s_ack at K >= N+1 -> mX_ack at K+1 -> IDLE at K+2.
- Back-to-back: the next grant can be issued in the IDLE cycle at K+2.
- Fairness: with both masters continuously requesting, grants alternate 0,1,0,1. A lone requester is granted repeatedly regardless of the pointer.
- A master that drops valid before being granted is simply not granted; no state changes.

Optional Feature:
- Macro: PIO_ARB_TIMEOUT_EN.
- Defined:
  - A cycle counter, width $clog2(TIMEOUT+1), clears on entry to REQ and increments each REQ cycle without s_ack.
  - When the count reaches TIMEOUT with no s_ack: clear s_valid, return to the owner mX_ack=1, mX_err=1, mX_rdata=0, and go to RESP.
  - An s_ack arriving in the same cycle as the timeout wins: normal completion.
  - A late s_ack is ignored per the REQ-only rule.
- Not defined: no counter; REQ waits indefinitely for s_ack.

Test Plan:
- Reset: hold reset=0 with m0_valid=1 and random s_* -> all outputs 0. Release reset -> s_valid=1 one cycle later with m0's addr.
- Single read: m0 reads addr 0x10, slave acks 2 cycles after s_valid with rdata 0xCAFE_F00D -> m0_ack one cycle later, m0_rdata=0xCAFE_F00D, m0_err=0, m1_ack stays 0.
- Contention: m0 and m1 request at the same time, from reset -> grant order m0, m1, m0, m1 over 4 transactions. s_addr matches the owner each time, and each master sees exactly its own acks.
- Error pass-through: m1 writes 0x20 with wdata 0x1234; slave returns s_ack with s_err=1 -> m1_ack=1, m1_err=1 for one cycle. s_wdata was 0x1234 for the whole REQ phase.
- Reset mid-transaction: assert reset while in REQ -> s_valid=0 immediately (asynchronously), no mX_ack. After release, the still-held request is reissued.
- Timeout (PIO_ARB_TIMEOUT_EN, TIMEOUT=8): the slave never acks -> m0_ack=1, m0_err=1, m0_rdata=0 after 8 REQ cycles. A later s_ack is ignored.
